// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS datapath.
// Sequences the shared ALU, memory port, IR, PC and register file over the
// fetch/decode/execute/memory/writeback steps. Outputs are Moore-decoded from
// State; only IRWrite/PCWrite in FETCH are qualified by MemReady.
// Optional feature: define MULTICYCLE_ADDI_EN to add addi support
// (ADDIEX/ADDIWB states); without it opcode 001000 is flagged Illegal.
//
// state  | code | meaning
// FETCH  | 0    | read instruction at PC, PC <= PC + 4 when memory ready
// DECODE | 1    | register read, branch target into ALUOut, dispatch on Op
// MEMADR | 2    | compute lw/sw effective address
// MEMRD  | 3    | load data read, waits on MemReady
// MEMWB  | 4    | write MDR into rt
// MEMWR  | 5    | store data write, waits on MemReady
// EXEC   | 6    | R-type ALU operation
// RWB    | 7    | write ALUOut into rd
// BRANCH | 8    | beq compare, conditional PC load from ALUOut
// JUMP   | 9    | PC <= jump target
// ADDIEX | 10   | addi ALU operation (feature only)
// ADDIWB | 11   | write ALUOut into rt (feature only)
// 12-15  | -    | unused: all outputs 0, back to FETCH

module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXEC   = STATE_W'(6),
        RWB    = STATE_W'(7),
        BRANCH = STATE_W'(8),
        JUMP   = STATE_W'(9),
        ADDIEX = STATE_W'(10),
        ADDIWB = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t state;
    state_t state_next;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore output decode; reset forces every output low.
    always_comb begin
        state_next  = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        Illegal     = 1'b0;

        case (state)
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                state_next = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                if (Op == OP_LW || Op == OP_SW) begin
                    state_next = MEMADR;
                end else if (Op == OP_RTYPE) begin
                    state_next = EXEC;
                end else if (Op == OP_BEQ) begin
                    state_next = BRANCH;
                end else if (Op == OP_J) begin
                    state_next = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                end else if (Op == OP_ADDI) begin
                    state_next = ADDIEX;
`endif
                end else begin
                    Illegal    = 1'b1;
                    state_next = FETCH;
                end
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                state_next = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                state_next = RWB;
            end
            RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_next  = FETCH;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                state_next = FETCH;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
`endif
            default: begin
                state_next = FETCH;
            end
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            Illegal     = 1'b0;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each cycle the stimulus process
// drives inputs and queues the hand-written expected State and control word;
// a monitor on the falling edge pops and compares.
// Control word bit order (MSB..LSB): PCWrite PCWriteCond IorD MemRead
// MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0]
// PCSource[1:0] Illegal.

module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    //                          PCW  PCWC IorD MRd  MWr  IRW  M2R  RDst RegW SrcA SrcB  ALUOp PCSrc Ill
    localparam logic [16:0] O_ZERO   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [16:0] O_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] O_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] O_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [16:0] O_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] O_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
`endif

    typedef struct {
        string      name;
        logic [3:0] state;
        logic [16:0] ctrl;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [16:0] act_ctrl;
    assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                       PCSource, Illegal};

    // Monitor: compare DUT against the oldest queued expectation mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            vectors++;
            if (State !== e.state || act_ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL %s: got state=%0d ctrl=%b, required state=%0d ctrl=%b",
                         e.name, State, act_ctrl, e.state, e.ctrl);
            end
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show this cycle.
    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic mr, input logic [3:0] st, input logic [16:0] ctrl);
        exp_t e;
        reset    = rst;
        Op       = op;
        MemReady = mr;
        e.name   = name;
        e.state  = st;
        e.ctrl   = ctrl;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        Op       = 6'b000000;
        MemReady = 1'b1;
        @(posedge clk);
        #1;

        step("reset_1", 1'b1, 6'b000000, 1'b1, 4'd0, O_ZERO);
        step("reset_2", 1'b1, 6'b000000, 1'b1, 4'd0, O_ZERO);

        // R-type
        step("r_fetch",  1'b0, 6'b000000, 1'b1, 4'd0, O_FETCH);
        step("r_decode", 1'b0, 6'b000000, 1'b1, 4'd1, O_DECODE);
        step("r_exec",   1'b0, 6'b000000, 1'b1, 4'd6, O_EXEC);
        step("r_rwb",    1'b0, 6'b000000, 1'b1, 4'd7, O_RWB);

        // lw with two wait cycles in MEMRD
        step("lw_fetch",  1'b0, 6'b100011, 1'b1, 4'd0, O_FETCH);
        step("lw_decode", 1'b0, 6'b100011, 1'b1, 4'd1, O_DECODE);
        step("lw_memadr", 1'b0, 6'b100011, 1'b1, 4'd2, O_MEMADR);
        step("lw_memrd0", 1'b0, 6'b100011, 1'b0, 4'd3, O_MEMRD);
        step("lw_memrd1", 1'b0, 6'b100011, 1'b0, 4'd3, O_MEMRD);
        step("lw_memrd2", 1'b0, 6'b100011, 1'b1, 4'd3, O_MEMRD);
        step("lw_memwb",  1'b0, 6'b100011, 1'b1, 4'd4, O_MEMWB);

        // sw with a fetch wait cycle
        step("sw_fwait",  1'b0, 6'b101011, 1'b0, 4'd0, O_FWAIT);
        step("sw_fetch",  1'b0, 6'b101011, 1'b1, 4'd0, O_FETCH);
        step("sw_decode", 1'b0, 6'b101011, 1'b1, 4'd1, O_DECODE);
        step("sw_memadr", 1'b0, 6'b101011, 1'b1, 4'd2, O_MEMADR);
        step("sw_memwr",  1'b0, 6'b101011, 1'b1, 4'd5, O_MEMWR);

        // beq (MemReady low must be ignored), then j
        step("beq_fetch",  1'b0, 6'b000100, 1'b1, 4'd0, O_FETCH);
        step("beq_decode", 1'b0, 6'b000100, 1'b0, 4'd1, O_DECODE);
        step("beq_branch", 1'b0, 6'b000100, 1'b0, 4'd8, O_BRANCH);
        step("j_fetch",    1'b0, 6'b000010, 1'b1, 4'd0, O_FETCH);
        step("j_decode",   1'b0, 6'b000010, 1'b1, 4'd1, O_DECODE);
        step("j_jump",     1'b0, 6'b000010, 1'b1, 4'd9, O_JUMP);

        // unsupported opcode
        step("ill_fetch",  1'b0, 6'b111111, 1'b1, 4'd0, O_FETCH);
        step("ill_decode", 1'b0, 6'b111111, 1'b1, 4'd1, O_DECILL);

        // addi
        step("addi_fetch",  1'b0, 6'b001000, 1'b1, 4'd0, O_FETCH);
`ifdef MULTICYCLE_ADDI_EN
        step("addi_decode", 1'b0, 6'b001000, 1'b1, 4'd1, O_DECODE);
        step("addi_ex",     1'b0, 6'b001000, 1'b1, 4'd10, O_ADDIEX);
        step("addi_wb",     1'b0, 6'b001000, 1'b1, 4'd11, O_ADDIWB);
`else
        step("addi_decode", 1'b0, 6'b001000, 1'b1, 4'd1, O_DECILL);
`endif

        // reset while a store waits on memory
        step("rsw_fetch",  1'b0, 6'b101011, 1'b1, 4'd0, O_FETCH);
        step("rsw_decode", 1'b0, 6'b101011, 1'b1, 4'd1, O_DECODE);
        step("rsw_memadr", 1'b0, 6'b101011, 1'b1, 4'd2, O_MEMADR);
        step("rsw_memwr",  1'b0, 6'b101011, 1'b0, 4'd5, O_MEMWR);
        step("rsw_reset",  1'b1, 6'b101011, 1'b0, 4'd5, O_ZERO);
        step("rsw_after0", 1'b0, 6'b101011, 1'b0, 4'd0, O_FWAIT);
        step("rsw_after1", 1'b0, 6'b101011, 1'b1, 4'd0, O_FETCH);

        // drain: bounded wait for the monitor to consume every vector
        for (int i = 0; i < 4 && expq.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expq.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
